// File: rtl/mux21_rr_arbiter.sv
// Round-robin, packet-locked arbiter that steers one of two requesters through
// a shared 2:1 word mux to a single valid/ready consumer.
module mux21_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_data,
  input  logic                 req0_last,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_data,
  input  logic                 req1_last,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 select,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] pkt_count0,
  output logic [CNT_WIDTH-1:0] pkt_count1,
  output logic [1:0]           dbg_state
);

  // Handshake: a beat moves when valid and ready are both high at a rising
  // edge; valid never waits on ready, and upstream holds data while valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 select_q, select_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_served_q, last_served_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic busy0, busy1, done0, done1;

  assign busy0 = (state_q == BUSY0);
  assign busy1 = (state_q == BUSY1);
  assign done0 = busy0 & req0_valid & out_ready & req0_last;
  assign done1 = busy1 & req1_valid & out_ready & req1_last;

  always_comb begin
    state_d       = state_q;
    select_d      = select_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that did not finish last goes next.
        if (req0_valid && (!req1_valid || last_served_q)) begin
          state_d  = BUSY0;
          select_d = 1'b0;
          grant_d  = 2'b01;
        end else if (req1_valid) begin
          state_d  = BUSY1;
          select_d = 1'b1;
          grant_d  = 2'b10;
        end
      end
      BUSY0: begin
        if (done0) begin
          last_served_d = 1'b0;
          cnt0_d        = cnt0_q + CNT_WIDTH'(1);
          if (req1_valid) begin
            state_d  = BUSY1;
            select_d = 1'b1;
            grant_d  = 2'b10;
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
          end
        end
      end
      BUSY1: begin
        if (done1) begin
          last_served_d = 1'b1;
          cnt1_d        = cnt1_q + CNT_WIDTH'(1);
          if (req0_valid) begin
            state_d  = BUSY0;
            select_d = 1'b0;
            grant_d  = 2'b01;
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      select_q      <= 1'b0;
      grant_q       <= 2'b00;
      last_served_q <= 1'b1;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      state_q       <= state_d;
      select_q      <= select_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  // Combinational datapath; select only moves on state changes, so it always
  // points at the granted requester while busy.
  assign out_data   = select_q ? req1_data : req0_data;
  assign out_valid  = (busy0 & req0_valid) | (busy1 & req1_valid);
  assign out_last   = (busy0 & req0_last) | (busy1 & req1_last);
  assign req0_ready = busy0 & out_ready;
  assign req1_ready = busy1 & out_ready;

  assign select     = select_q;
  assign grant      = grant_q;
  assign pkt_count0 = cnt0_q;
  assign pkt_count1 = cnt1_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Directed bench for mux21_rr_arbiter: a cycle model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_mux21_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       r0v, r0l, r1v, r1l, ordy;
  logic [7:0] r0d, r1d;

  logic        req0_ready, req1_ready, out_valid, out_last, select;
  logic [7:0]  out_data;
  logic [1:0]  grant, dbg_state;
  logic [15:0] pkt_count0, pkt_count1;

  logic       w_req0_ready, w_req1_ready, w_out_valid, w_out_last, w_select;
  logic [7:0] w_out_data;
  logic [1:0] w_grant, w_dbg_state;
  logic [3:0] w_pkt_count0, w_pkt_count1;

  int n_vec = 0;
  int n_err = 0;

  mux21_rr_arbiter #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(req0_ready),
    .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(ordy),
    .select(select), .grant(grant), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1),
    .dbg_state(dbg_state)
  );

  mux21_rr_arbiter #(.WIDTH(8), .CNT_WIDTH(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(w_req0_ready),
    .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(w_req1_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_last(w_out_last), .out_ready(ordy),
    .select(w_select), .grant(w_grant), .pkt_count0(w_pkt_count0), .pkt_count1(w_pkt_count1),
    .dbg_state(w_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 nobody, 0 or 1 = requester holding the packet lock.
  int   m_owner = -1;
  int   m_ls    = 1;
  logic m_sel   = 1'b0;
  int   m_cnt0  = 0;
  int   m_cnt1  = 0;

  always @(posedge clk or negedge rst_n) begin : model_blk
    int   nxt;
    logic v_own, l_own, v_oth;
    if (!rst_n) begin
      m_owner <= -1;
      m_ls    <= 1;
      m_sel   <= 1'b0;
      m_cnt0  <= 0;
      m_cnt1  <= 0;
    end else begin
      nxt = m_owner;
      if (m_owner < 0) begin
        if (r0v && r1v) nxt = (m_ls == 1) ? 0 : 1;
        else if (r0v)   nxt = 0;
        else if (r1v)   nxt = 1;
      end else begin
        v_own = (m_owner == 0) ? r0v : r1v;
        l_own = (m_owner == 0) ? r0l : r1l;
        v_oth = (m_owner == 0) ? r1v : r0v;
        if (v_own && ordy && l_own) begin
          m_ls <= m_owner;
          if (m_owner == 0) m_cnt0 <= m_cnt0 + 1;
          else              m_cnt1 <= m_cnt1 + 1;
          nxt = v_oth ? 1 - m_owner : -1;
        end
      end
      m_owner <= nxt;
      if (nxt >= 0) m_sel <= (nxt == 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp_blk
    logic [1:0] eg;
    logic       ev;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    ev = (m_owner == 0) ? r0v : (m_owner == 1) ? r1v : 1'b0;
    chk("grant", 32'(grant), 32'(eg));
    chk("select", 32'(select), 32'(m_sel));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("req0_ready", 32'(req0_ready), 32'((m_owner == 0) && ordy));
    chk("req1_ready", 32'(req1_ready), 32'((m_owner == 1) && ordy));
    if (ev) begin
      chk("out_data", 32'(out_data), 32'((m_owner == 0) ? r0d : r1d));
      chk("out_last", 32'(out_last), 32'((m_owner == 0) ? r0l : r1l));
    end
    chk("pkt_count0", 32'(pkt_count0), 32'(m_cnt0 % 65536));
    chk("pkt_count1", 32'(pkt_count1), 32'(m_cnt1 % 65536));
    chk("w_pkt_count0", 32'(w_pkt_count0), 32'(m_cnt0 % 16));
    chk("w_grant", 32'(w_grant), 32'(eg));
  end

  // ---------------- driver tasks ----------------
  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] d);
    logic acc;
    int   t;
    r0v = 1'b1; r0d = d; r0l = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 20) begin
      at_neg();
      acc = req0_ready;
      t++;
      adv();
    end
    chk("send0_accept", 32'(acc), 32'd1);
    r0v = 1'b0; r0l = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] exp_g [8];
  int         pk0, pk1, bt0, bt1;
  logic       a0, a1;

  initial begin
    rst_n = 1'b1; ordy = 1'b1;
    r0v = 0; r0l = 0; r0d = '0; r1v = 0; r1l = 0; r1d = '0;
    #1 rst_n = 1'b0;
    at_neg();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt0", 32'(pkt_count0), 32'd0);
    rst_n = 1'b1;
    adv();

    // 3-beat packet from req0
    r0v = 1; r0d = 8'h11; r0l = 0;
    at_neg(); chk("t1_idle_valid", 32'(out_valid), 0); chk("t1_idle_rdy0", 32'(req0_ready), 0);
    adv();
    at_neg(); chk("t1_b1_data", 32'(out_data), 32'h11); chk("t1_grant", 32'(grant), 32'b01);
    chk("t1_select", 32'(select), 0);
    adv();
    r0d = 8'h22;
    at_neg(); chk("t1_b2_data", 32'(out_data), 32'h22);
    adv();
    r0d = 8'h33; r0l = 1;
    at_neg(); chk("t1_b3_data", 32'(out_data), 32'h33); chk("t1_b3_last", 32'(out_last), 1);
    adv();
    r0v = 0; r0l = 0;
    at_neg(); chk("t1_end_grant", 32'(grant), 0); chk("t1_cnt0", 32'(pkt_count0), 1);
    adv();

    // both requesters, 2-beat packets; req0 served last so req1 goes first
    exp_g = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    r0v = 1; r0d = 8'h40; r0l = 0; r1v = 1; r1d = 8'h50; r1l = 0;
    pk0 = 0; pk1 = 0; bt0 = 0; bt1 = 0;
    for (int c = 0; c < 9; c++) begin
      at_neg();
      a0 = req0_ready & r0v;
      a1 = req1_ready & r1v;
      if (c > 0) chk("t2_grant", 32'(grant), 32'(exp_g[c-1]));
      adv();
      if (a0) begin
        bt0++; r0d = r0d + 8'd1;
        if (r0l) begin pk0++; if (pk0 == 2) r0v = 0; end
        r0l = (bt0 % 2 == 1);
      end
      if (a1) begin
        bt1++; r1d = r1d + 8'd1;
        if (r1l) begin pk1++; if (pk1 == 2) r1v = 0; end
        r1l = (bt1 % 2 == 1);
      end
    end
    r0l = 0; r1l = 0;
    at_neg(); chk("t2_grant_idle", 32'(grant), 0);
    chk("t2_cnt0", 32'(pkt_count0), 3); chk("t2_cnt1", 32'(pkt_count1), 2);
    adv();

    // req1 4-beat packet is not preempted by req0
    r1v = 1; r1d = 8'hA1; r1l = 0;
    at_neg(); adv();
    at_neg(); chk("t3_b1_data", 32'(out_data), 32'hA1); chk("t3_grant1", 32'(grant), 32'b10);
    adv();
    r1d = 8'hA2; r0v = 1; r0d = 8'hB1; r0l = 1;
    at_neg(); chk("t3_rdy0_b2", 32'(req0_ready), 0);
    adv();
    r1d = 8'hA3;
    at_neg(); chk("t3_rdy0_b3", 32'(req0_ready), 0);
    adv();
    r1d = 8'hA4; r1l = 1;
    at_neg(); chk("t3_rdy0_b4", 32'(req0_ready), 0); chk("t3_last", 32'(out_last), 1);
    adv();
    r1v = 0; r1l = 0;
    at_neg(); chk("t3_grant0", 32'(grant), 32'b01); chk("t3_rdy0", 32'(req0_ready), 1);
    chk("t3_data0", 32'(out_data), 32'hB1);
    adv();
    r0v = 0; r0l = 0;
    at_neg(); chk("t3_cnt0", 32'(pkt_count0), 4); chk("t3_cnt1", 32'(pkt_count1), 3);
    adv();

    // back-pressure for 3 cycles on the 0xA5 beat
    r0v = 1; r0d = 8'h5A; r0l = 0;
    at_neg(); adv();
    at_neg(); chk("t4_b1_data", 32'(out_data), 32'h5A);
    adv();
    r0d = 8'hA5; r0l = 1; ordy = 0;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("t4_hold_data", 32'(out_data), 32'hA5); chk("t4_hold_sel", 32'(select), 0);
      chk("t4_hold_cnt", 32'(pkt_count0), 4); chk("t4_hold_rdy", 32'(req0_ready), 0);
      adv();
    end
    ordy = 1;
    at_neg(); chk("t4_rdy", 32'(req0_ready), 1); chk("t4_data", 32'(out_data), 32'hA5);
    adv();
    r0v = 0; r0l = 0;
    at_neg(); chk("t4_cnt0", 32'(pkt_count0), 5); chk("t4_grant", 32'(grant), 0);
    adv();

    // reset during beat 2 of a req1 packet
    r1v = 1; r1d = 8'hC1; r1l = 0;
    at_neg(); adv();
    at_neg(); chk("t5_b1_data", 32'(out_data), 32'hC1);
    adv();
    r1d = 8'hC2;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant), 0); chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_rdy1", 32'(req1_ready), 0); chk("t5_rst_sel", 32'(select), 0);
    chk("t5_rst_cnt0", 32'(pkt_count0), 0); chk("t5_rst_cnt1", 32'(pkt_count1), 0);
    r1v = 0;
    at_neg(); rst_n = 1'b1;
    adv();
    r0v = 1; r0d = 8'hD0; r0l = 1; r1v = 1; r1d = 8'hD1; r1l = 1;
    at_neg(); chk("t5_idle_grant", 32'(grant), 0);
    adv();
    at_neg(); chk("t5_first_grant", 32'(grant), 32'b01); chk("t5_d0", 32'(out_data), 32'hD0);
    adv();
    r0v = 0; r0l = 0;
    at_neg(); chk("t5_second_grant", 32'(grant), 32'b10); chk("t5_d1", 32'(out_data), 32'hD1);
    chk("t5_sel1", 32'(select), 1);
    adv();
    r1v = 0; r1l = 0;
    at_neg(); chk("t5_cnt0", 32'(pkt_count0), 1); chk("t5_cnt1", 32'(pkt_count1), 1);
    adv();

    // counter wrap on the 4-bit instance
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    adv();
    for (int i = 0; i < 17; i++) begin
      send0(8'(i));
      if (i == 14) begin
        at_neg(); chk("t6_w_allones", 32'(w_pkt_count0), 32'hF);
      end
    end
    at_neg();
    chk("t6_w_wrap", 32'(w_pkt_count0), 1);
    chk("t6_cnt0", 32'(pkt_count0), 17);
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
